// File: rtl/viexo_axi4_pkg.sv
// Shared types and helpers for the viexo AXI4 write slave and its address generator.
// Optional WRAP support is controlled by VIEXO_AXI4_WSLAVE_WRAP_EN in the modules that import this.
package viexo_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  // Byte lanes touched by one beat of 2**size bytes, aligned down inside the bus word.
  function automatic logic [15:0] lane_mask(input logic [3:0] addr_lsbs, input logic [2:0] size);
    logic [15:0] m;
    int          nbytes;
    int          off;
    nbytes = 1 << size;
    off    = int'(addr_lsbs) & ~(nbytes - 1);
    m      = '0;
    for (int i = 0; i < 16; i++) begin
      m[i] = (i >= off) && (i < off + nbytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/viexo_axi4_addrgen.sv
// Combinational AXI4 next-beat address and byte-lane mask; shared with the future read slave.
// WRAP arithmetic exists only when VIEXO_AXI4_WSLAVE_WRAP_EN is defined.
module viexo_axi4_addrgen
  import viexo_axi4_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2:0]          size,
  input  logic [7:0]          len,
  input  logic [1:0]          burst,
  output logic [ADDR_W-1:0]   next_addr,
  output logic [DATA_W/8-1:0] strb_mask
);

  localparam int LSB    = $clog2(DATA_W / 8);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] step;

  assign step      = ADDR_W'(32'd1 << size);
  assign strb_mask = STRB_W'(lane_mask(4'(addr[LSB-1:0]), size));

`ifdef VIEXO_AXI4_WSLAVE_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;

  // Wrap window is (len+1) beats long; legal lengths make it a power of two.
  assign wrap_mask = ADDR_W'(((32'(len) + 32'd1) << size) - 32'd1);

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end
`else
  logic len_unused;

  assign len_unused = ^len;

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      default:    next_addr = addr;
    endcase
  end
`endif

endmodule

// File: rtl/viexo_axi4_wslave.sv
// AXI4 write-channel slave driving an external byte-enabled memory port, one burst at a time.
// Define VIEXO_AXI4_WSLAVE_WRAP_EN to accept WRAP bursts; otherwise they are answered with SLVERR.
module viexo_axi4_wslave
  import viexo_axi4_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [ID_W-1:0]                       awid,
  input  logic [31:0]                           awaddr,
  input  logic [7:0]                            awlen,
  input  logic [2:0]                            awsize,
  input  logic [1:0]                            awburst,
  input  logic                                  awvalid,
  output logic                                  awready,
  input  logic [DATA_W-1:0]                     wdata,
  input  logic [DATA_W/8-1:0]                   wstrb,
  input  logic                                  wlast,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic [ID_W-1:0]                       bid,
  output logic [1:0]                            bresp,
  output logic                                  bvalid,
  input  logic                                  bready,
  output logic                                  mem_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_addr,
  output logic [DATA_W-1:0]                     mem_wdata,
  output logic [DATA_W/8-1:0]                   mem_wstrb
);

  localparam int          LSB      = $clog2(DATA_W / 8);
  localparam int          STRB_W   = DATA_W / 8;
  localparam int          MA_W     = ADDR_W - LSB;
  localparam logic [2:0]  MAX_SIZE = 3'(LSB);

  state_t              state_q, state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic                mem_we_q, mem_we_d;
  logic [MA_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic [8:0]          cnt_q, cnt_d;

  logic [ADDR_W-1:0]   next_addr;
  logic [STRB_W-1:0]   lane_strb;
  logic                aw_err;
  logic                wrap_err;
  logic [9:0]          beat_num;
  logic [9:0]          len_p1;
  logic                beat_err;
  logic                err_now;

  viexo_axi4_addrgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addrgen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .strb_mask (lane_strb)
  );

`ifdef VIEXO_AXI4_WSLAVE_WRAP_EN
  assign wrap_err = (awburst == BURST_WRAP) &&
                    (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                     ((awaddr & ((32'd1 << awsize) - 32'd1)) != '0));
`else
  assign wrap_err = (awburst == BURST_WRAP);
`endif

  assign aw_err = ((awaddr >> ADDR_W) != '0) || (awsize > MAX_SIZE) ||
                  (awburst == BURST_RSVD) || wrap_err;

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    beat_num    = {1'b0, cnt_q} + 10'd1;
    len_p1      = {2'b00, len_q} + 10'd1;
    beat_err    = 1'b0;
    err_now     = err_q;

    case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          id_d      = awid;
          addr_d    = awaddr[ADDR_W-1:0];
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          err_d     = aw_err;
          cnt_d     = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (wvalid && wready_q) begin
          // A beat that breaks the length contract is itself not written.
          beat_err = wlast ? (beat_num != len_p1) : (beat_num > len_p1);
          err_now  = err_q || beat_err;
          err_d    = err_now;
          cnt_d    = (cnt_q == 9'd256) ? cnt_q : cnt_q + 9'd1;
          addr_d   = next_addr;
          if (!err_now) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[ADDR_W-1:LSB];
            mem_wdata_d = wdata;
            mem_wstrb_d = wstrb & lane_strb;
          end
          if (wlast) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = err_now ? RESP_SLVERR : RESP_OKAY;
            bid_d    = id_q;
            state_d  = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      bid_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign bid       = bid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
